// File: rtl/studio2_keypad.sv
// -----------------------------------------------------------------------------
// studio2_keypad
//   Keypad front end for the Studio II core. PS/2 key events are decoded into
//   the two 10-key hex keypads, the CPU writes the key-select latch with OUT 2,
//   and the selected key's state is presented on the active-low EF3/EF4 flags.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   ps2_key    [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code
//   io_out     CPU output strobe (one cycle)
//   io_n       CPU N lines
//   io_dout    CPU output data
//   ef3_n      active-low: selected key is down on keypad 1
//   ef4_n      active-low: selected key is down on keypad 2
//   kp1_state  bit k = digit k held on keypad 1
//   kp2_state  bit k = digit k held on keypad 2
//   key_sel    current key-select latch value
// -----------------------------------------------------------------------------
module studio2_keypad #(
  parameter bit         KP2_ENABLE = 1'b1,
  parameter logic [3:0] SEL_RESET  = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        io_out,
  input  logic [2:0]  io_n,
  input  logic [7:0]  io_dout,
  output logic        ef3_n,
  output logic        ef4_n,
  output logic [9:0]  kp1_state,
  output logic [9:0]  kp2_state,
  output logic [3:0]  key_sel
);

  // Keypad 1 layout: digits 1..9 on the main row keys, 0 on the '0' key.
  function automatic logic [9:0] kp1_mask(input logic [7:0] code);
    case (code)
      8'h45:   kp1_mask = 10'h001;
      8'h16:   kp1_mask = 10'h002;
      8'h1E:   kp1_mask = 10'h004;
      8'h26:   kp1_mask = 10'h008;
      8'h25:   kp1_mask = 10'h010;
      8'h2E:   kp1_mask = 10'h020;
      8'h36:   kp1_mask = 10'h040;
      8'h3D:   kp1_mask = 10'h080;
      8'h3E:   kp1_mask = 10'h100;
      8'h46:   kp1_mask = 10'h200;
      default: kp1_mask = 10'h000;
    endcase
  endfunction

  // Keypad 2 layout: numeric keypad digits 0..9.
  function automatic logic [9:0] kp2_mask(input logic [7:0] code);
    case (code)
      8'h70:   kp2_mask = 10'h001;
      8'h69:   kp2_mask = 10'h002;
      8'h72:   kp2_mask = 10'h004;
      8'h7A:   kp2_mask = 10'h008;
      8'h6B:   kp2_mask = 10'h010;
      8'h73:   kp2_mask = 10'h020;
      8'h74:   kp2_mask = 10'h040;
      8'h6C:   kp2_mask = 10'h080;
      8'h75:   kp2_mask = 10'h100;
      8'h7D:   kp2_mask = 10'h200;
      default: kp2_mask = 10'h000;
    endcase
  endfunction

  logic        tog_p0;
  logic        vld_p0;
  logic        dec_en;
  logic [9:0]  mask1;
  logic [9:0]  mask2;
  logic [9:0]  kp1_nxt;
  logic [9:0]  kp2_nxt;
  logic        sel_wr;
  logic [15:0] kp1_ext;
  logic [15:0] kp2_ext;
  logic        hit1;
  logic        hit2;

  // Stage 0: event detect and keypad/latch next-state
  always_comb begin
    vld_p0  = ps2_key[10] ^ tog_p0;
    dec_en  = vld_p0 && !ps2_key[8];
    mask1   = dec_en ? kp1_mask(ps2_key[7:0]) : 10'h000;
    mask2   = (dec_en && KP2_ENABLE) ? kp2_mask(ps2_key[7:0]) : 10'h000;
    kp1_nxt = ps2_key[9] ? (kp1_state | mask1) : (kp1_state & ~mask1);
    kp2_nxt = ps2_key[9] ? (kp2_state | mask2) : (kp2_state & ~mask2);
    sel_wr  = io_out && (io_n == 3'd2);
  end

  // Zero-extending to 16 bits makes selects 10..15 read as "not held".
  always_comb begin
    kp1_ext = {6'b0, kp1_state};
    kp2_ext = {6'b0, kp2_state};
    hit1    = kp1_ext[key_sel];
    hit2    = KP2_ENABLE && kp2_ext[key_sel];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tog_p0    <= ps2_key[10];
      kp1_state <= 10'h000;
      kp2_state <= 10'h000;
      key_sel   <= SEL_RESET;
    end else begin
      tog_p0    <= ps2_key[10];
      kp1_state <= kp1_nxt;
      kp2_state <= kp2_nxt;
      if (sel_wr) key_sel <= io_dout[3:0];
    end
  end

  // Stage 1: flags sampled from the registered keypad state and latch
  always_ff @(posedge clk) begin
    if (reset) begin
      ef3_n <= 1'b1;
      ef4_n <= 1'b1;
    end else begin
      ef3_n <= ~hit1;
      ef4_n <= ~hit2;
    end
  end

endmodule

// File: doc/studio2_keypad.md
Name: studio2_keypad

Overview:
Keypad front end for the Studio II core. It converts PS/2 key events into the two 10-key hex keypads and holds the key-select latch written by the CPU with OUT 2. It drives the active-low EF3/EF4 flags the CPU polls. It sits between the PS/2 input and the cdp1802 EF/IO pins, replacing ad-hoc key decoding in the top level.

Parameters:
KP2_ENABLE, 1, when 0 keypad 2 is never populated and ef4_n stays 1
SEL_RESET, 4'hF, key-select latch value after reset (out of range, so no key is selected)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended, [7:0] scan code
io_out  in  1  CPU output strobe, one cycle
io_n  in  3  CPU N lines
io_dout  in  8  CPU output data
ef3_n  out  1  active-low: selected key is down on keypad 1
ef4_n  out  1  active-low: selected key is down on keypad 2
kp1_state  out  10  bit k = digit k held on keypad 1
kp2_state  out  10  bit k = digit k held on keypad 2
key_sel  out  4  current key-select latch value

Behaviour:
- Single clock domain; every register is updated only on the rising edge of clk.
- Reset (synchronous, active-high):
  - kp1_state=0, kp2_state=0, key_sel=SEL_RESET, ef3_n=1, ef4_n=1.
  - The toggle history register loads ps2_key[10], so the next cycle produces no event.
- Event detect:
  - An event is a cycle where ps2_key[10] differs from the registered previous value.
  - At most one event per toggle. A stable toggle produces no event.
- Decode (applies only on an event with ps2_key[8]=0; extended codes are ignored):
  - Keypad 1, digits 1..9,0: codes 16,1E,26,25,2E,36,3D,3E,46,45.
  - Keypad 2, digits 0..9: codes 70,69,72,7A,6B,73,74,6C,75,7D. Decoded only when KP2_ENABLE=1.
  - Press (ps2_key[9]=1) sets the digit's bit; release clears it. All other bits are unchanged.
  - Multiple simultaneous held keys are tracked independently.
  - Unmapped codes cause no state change.
- Select latch:
  - When io_out=1 and io_n=3'd2, key_sel <= io_dout[3:0]. io_dout[7:4] is ignored.
  - Other io_n values are ignored.
- Flags (registered):
  - ef3_n <= ~(key_sel<10 && kp1_state[key_sel]).
  - ef4_n <= ~(KP2_ENABLE && key_sel<10 && kp2_state[key_sel]).
  - key_sel in 10..15 forces both flags to 1.
- Latency:
  - State and latch registers update at the edge that samples the event or OUT.
  - The flags reflect that update one edge later, i.e. 2 edges from input to flag.
- Simultaneous event and OUT 2 in the same cycle: both updates commit at the same edge. The flags at the following edge use both new values.
- Repeated press of an already-held key (typematic) is idempotent. A release of a non-held key is idempotent.
- Reset asserted mid-operation clears all state in one cycle; held keys must be re-pressed.

Test Plan:
- Reset, ps2_key toggle held constant → kp1_state=0, kp2_state=0, key_sel=F, ef3_n=ef4_n=1; no spurious event on the first cycle after reset.
- OUT 2 with io_dout=8'h35, then toggle with pressed=1, code 2E → key_sel=5, kp1_state=10'h020, ef3_n=0 exactly 2 edges after the toggle; release 2E → ef3_n=1 after 2 edges.
- Press code 70 (keypad 2, digit 0) with key_sel=0 → ef4_n=0, ef3_n=1; rerun with KP2_ENABLE=0 → kp2_state stays 0, ef4_n stays 1.
- Hold keypad-1 digits 3 and 7, OUT 2 with sel=7, then OUT 2 with io_dout=8'h0C → ef3_n=0, then ef3_n=1 (out-of-range select); release of digit 3 leaves kp1_state=10'h080.
- Same cycle: toggle pressed=1 code 16 plus io_out with io_n=2, io_dout=1 → both commit at one edge; ef3_n=0 one edge later.
- Extended event (ps2_key[8]=1, code 70), unmapped code 1C, and a repeated press of 16 → no state change other than the idempotent set of bit 1; assert reset while keys are held → all state clears in one cycle.
